// File: rtl/tsu_bus_arb.sv
// tsu_bus_arb: two-requester arbiter in front of a single bus2ip slave port.
// Only one transaction is outstanding at a time. Every output is registered.
// Optional feature: define TSU_ARB_RR_EN for round-robin arbitration.
// Without it, m0 always wins a tie.
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// ISSUE | one-cycle read or write strobe with the latched address/data
// WAIT  | read only; capture slave data into the winner's rdata
// DONE  | one-cycle ack to the winner
module tsu_bus_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          bus2ip_clk,
    input  logic          bus2ip_rst,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdata_o,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] bus2ip_addr_o,
    output logic [DW-1:0] bus2ip_data_o,
    output logic          bus2ip_rd_ce_o,
    output logic          bus2ip_wr_ce_o,
    input  logic [DW-1:0] ip2bus_data_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   win_m1;   // latched winner id: 1 = m1
    logic   lat_we;   // latched direction of the granted transaction
    logic   sel_m1;   // combinational winner for this IDLE cycle

`ifdef TSU_ARB_RR_EN
    logic   rr_ptr;   // requester favoured on a tie: 1 = m1

    // Round-robin pick: the pointer breaks ties, and a lone requester always wins.
    always_comb begin
        sel_m1 = 1'b0;
        if (m0_req_i && m1_req_i)
            sel_m1 = rr_ptr;
        else
            sel_m1 = m1_req_i;
    end
`else
    // Fixed-priority pick: m1 wins only when m0 is not requesting.
    always_comb begin
        sel_m1 = m1_req_i && !m0_req_i;
    end
`endif

    // Main sequencer. State and all outputs are updated together, so every output is a flop.
    always_ff @(posedge bus2ip_clk or posedge bus2ip_rst) begin
        if (bus2ip_rst) begin
            state          <= IDLE;
            win_m1         <= 1'b0;
            lat_we         <= 1'b0;
            m0_ack_o       <= 1'b0;
            m1_ack_o       <= 1'b0;
            m0_rdata_o     <= '0;
            m1_rdata_o     <= '0;
            bus2ip_addr_o  <= '0;
            bus2ip_data_o  <= '0;
            bus2ip_rd_ce_o <= 1'b0;
            bus2ip_wr_ce_o <= 1'b0;
            busy_o         <= 1'b0;
`ifdef TSU_ARB_RR_EN
            rr_ptr         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state          <= ISSUE;
                        busy_o         <= 1'b1;
                        win_m1         <= sel_m1;
                        // The bus address/data registers hold the latched request.
                        // Later changes on the requester inputs are ignored.
                        lat_we         <= sel_m1 ? m1_we_i : m0_we_i;
                        bus2ip_addr_o  <= sel_m1 ? m1_addr_i : m0_addr_i;
                        bus2ip_data_o  <= sel_m1 ? m1_wdata_i : m0_wdata_i;
                        bus2ip_wr_ce_o <= sel_m1 ? m1_we_i : m0_we_i;
                        bus2ip_rd_ce_o <= sel_m1 ? !m1_we_i : !m0_we_i;
                    end
                end
                ISSUE: begin
                    bus2ip_rd_ce_o <= 1'b0;
                    bus2ip_wr_ce_o <= 1'b0;
                    if (lat_we) begin
                        state    <= DONE;
                        m0_ack_o <= !win_m1;
                        m1_ack_o <= win_m1;
                    end else begin
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // The slave registers its data one cycle after rd_ce, so it is valid now.
                    if (win_m1)
                        m1_rdata_o <= ip2bus_data_i;
                    else
                        m0_rdata_o <= ip2bus_data_i;
                    state    <= DONE;
                    m0_ack_o <= !win_m1;
                    m1_ack_o <= win_m1;
                end
                DONE: begin
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    m0_ack_o <= 1'b0;
                    m1_ack_o <= 1'b0;
`ifdef TSU_ARB_RR_EN
                    rr_ptr   <= !win_m1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
